// File: rtl/btb_updater.sv
// btb_updater: buffers execute-stage misprediction reports and issues
// single-entry BTB write/invalidate commands with round-robin allocation.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   upd_*             misprediction report in (valid/ready handshake)
//   btb_wbusy         BTB write port taken by the lookup side this cycle
//   btb_w*            registered BTB write command (btb_we = strobe)
module btb_updater #(
  parameter int BTBNUM    = 32,
  parameter int BTBGROUP  = 2,
  parameter int BTBTAGLEN = 6,
  parameter int FIFODEPTH = 4,
  parameter int BTBIDLEN  = $clog2(BTBNUM)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [31:0]          upd_pc,
  input  logic [31:0]          upd_target,
  input  logic                 upd_taken,
  input  logic                 upd_pred_hit,
  input  logic [BTBIDLEN-1:0]  upd_pred_index,
  input  logic                 btb_wbusy,
  output logic                 btb_we,
  output logic [BTBIDLEN-1:0]  btb_windex,
  output logic                 btb_wvalid,
  output logic [BTBTAGLEN-1:0] btb_wtag,
  output logic [31:0]          btb_wtarget
);

  localparam int NGRP = BTBNUM / BTBGROUP;
  localparam int GRPW = $clog2(NGRP);
  localparam int WAYW = $clog2(BTBGROUP);
  localparam int PTRW = $clog2(FIFODEPTH);
  localparam int CNTW = $clog2(FIFODEPTH + 1);

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         target;
    logic                taken;
    logic                hit;
    logic [BTBIDLEN-1:0] index;
  } rpt_t;

  rpt_t            fifo [FIFODEPTH];
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic [CNTW-1:0] count;
  logic [WAYW-1:0] rr [NGRP];

  logic                 push;
  logic                 pop;
  rpt_t                 head;
  logic [GRPW-1:0]      grp;
  logic [WAYW-1:0]      way;
  logic [BTBTAGLEN-1:0] tag;
  logic                 issue;

  // Same fold as the lookup path: pc[31:2] XORed in TAGLEN-bit slices,
  // bit k of pc[31:2] lands on tag bit k mod TAGLEN.
  function automatic logic [BTBTAGLEN-1:0] fold(input logic [31:0] pc);
    logic [BTBTAGLEN-1:0] t;
    t = '0;
    for (int i = 2; i < 32; i++)
      t[(i-2) % BTBTAGLEN] = t[(i-2) % BTBTAGLEN] ^ pc[i];
    return t;
  endfunction

  assign upd_ready = (count != CNTW'(FIFODEPTH));
  assign push      = upd_valid && upd_ready;
  assign pop       = (count != '0) && !btb_wbusy;
  assign head      = fifo[rd_ptr];
  assign grp       = head.pc[GRPW+1:2];
  assign way       = rr[grp];
  assign tag       = fold(head.pc);
  // Not-taken reports that missed need no BTB change.
  assign issue     = pop && (head.taken || head.hit);

  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= '{upd_pc, upd_target, upd_taken,
                         upd_pred_hit, upd_pred_index};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      btb_we      <= 1'b0;
      btb_windex  <= '0;
      btb_wvalid  <= 1'b0;
      btb_wtag    <= '0;
      btb_wtarget <= '0;
      for (int g = 0; g < NGRP; g++)
        rr[g] <= '0;
    end else begin
      btb_we <= issue;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      if (issue) begin
        btb_wvalid  <= head.taken;
        btb_wtag    <= tag;
        btb_wtarget <= head.target;
        if (head.hit) begin
          btb_windex <= head.index;
        end else begin
          btb_windex <= {grp, way};
          rr[grp]    <= (way == WAYW'(BTBGROUP-1)) ? '0 : way + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_updater.sv
// tb_btb_updater: scoreboard bench for btb_updater.
// Expected writes are queued at push and compared when btb_we fires.
module tb_btb_updater;

  logic        clk = 0;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_pred_hit;
  logic [4:0]  upd_pred_index;
  logic        btb_wbusy;
  logic        btb_we;
  logic [4:0]  btb_windex;
  logic        btb_wvalid;
  logic [5:0]  btb_wtag;
  logic [31:0] btb_wtarget;

  btb_updater dut (
    .clk            (clk),
    .reset          (reset),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .upd_pred_hit   (upd_pred_hit),
    .upd_pred_index (upd_pred_index),
    .btb_wbusy      (btb_wbusy),
    .btb_we         (btb_we),
    .btb_windex     (btb_windex),
    .btb_wvalid     (btb_wvalid),
    .btb_wtag       (btb_wtag),
    .btb_wtarget    (btb_wtarget)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic        v;
    logic [5:0]  tag;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  int   mrr [16];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_writes = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] tagf(input logic [31:0] pc);
    logic [31:0] v;
    logic [5:0]  t;
    v = pc >> 2;
    t = '0;
    for (int k = 0; k < 5; k++) begin
      t = t ^ v[5:0];
      v = v >> 6;
    end
    return t;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int g = 0; g < 16; g++) mrr[g] = 0;
  endtask

  task automatic model(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic hit,
                       input logic [4:0] idx);
    exp_t e;
    int   g;
    if (tk || hit) begin
      g = int'((pc >> 2) % 16);
      if (hit) begin
        e.idx = idx;
      end else begin
        e.idx = 5'(g * 2 + mrr[g]);
        mrr[g] = (mrr[g] + 1) % 2;
      end
      e.v   = tk;
      e.tag = tagf(pc);
      e.tgt = tgt;
      q.push_back(e);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] tgt,
                      input logic tk, input logic hit,
                      input logic [4:0] idx);
    int t;
    t = 0;
    upd_valid      = 1;
    upd_pc         = pc;
    upd_target     = tgt;
    upd_taken      = tk;
    upd_pred_hit   = hit;
    upd_pred_index = idx;
    while (!upd_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!upd_ready) chk("push_timeout", 0, 1);
    model(pc, tgt, tk, hit, idx);
    @(posedge clk); #1;
    upd_valid = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!reset && btb_we) begin
      n_writes++;
      if (q.size() == 0) begin
        chk("spurious_we", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("w_index", btb_windex, e.idx);
        chk("w_valid", btb_wvalid, e.v);
        if (e.v) begin
          chk("w_tag", btb_wtag, e.tag);
          chk("w_target", btb_wtarget, e.tgt);
        end
      end
    end
  end

  initial begin
    int w;
    reset = 1;
    upd_valid = 0;
    upd_pc = 0;
    upd_target = 0;
    upd_taken = 0;
    upd_pred_hit = 0;
    upd_pred_index = 0;
    btb_wbusy = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 0;

    chk("rst_ready", upd_ready, 1);
    chk("rst_we", btb_we, 0);
    chk("rst_windex", btb_windex, 0);
    chk("rst_wvalid", btb_wvalid, 0);
    chk("rst_wtag", btb_wtag, 0);
    chk("rst_wtarget", btb_wtarget, 0);

    push(32'h1C00_0010, 32'h1C00_0100, 1, 0, 0);
    chk("lat_e0_we", btb_we, 0);
    @(posedge clk); #1;
    chk("lat_e1_we", btb_we, 1);
    chk("a1_windex", btb_windex, 8);
    chk("a1_wvalid", btb_wvalid, 1);
    chk("a1_wtarget", btb_wtarget, 32'h1C00_0100);
    @(posedge clk); #1;
    chk("we_one_cycle", btb_we, 0);
    chk("hold_windex", btb_windex, 8);

    push(32'h1C00_0050, 32'h1C00_0300, 1, 0, 0);
    push(32'h1C00_0090, 32'h1C00_0400, 1, 0, 0);
    drain();

    push(32'h1C00_0034, 32'h1C00_0200, 1, 1, 13);
    drain();
    push(32'h1C00_0110, 32'h1C00_0500, 1, 0, 0);
    drain();

    push(32'h1C00_0014, 32'h0000_0000, 0, 1, 5);
    drain();
    w = n_writes;
    push(32'h1C00_0018, 32'h1C00_0600, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("drop_no_we", n_writes, w);

    btb_wbusy = 1;
    push(32'h1C00_001C, 32'h1C00_0700, 1, 0, 0);
    push(32'h1C00_005C, 32'h1C00_0704, 1, 0, 0);
    push(32'h1C00_0020, 32'h1C00_0708, 1, 1, 17);
    push(32'h1C00_009C, 32'h1C00_070C, 1, 0, 0);
    chk("full_ready", upd_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("busy_no_we", btb_we, 0);
    chk("busy_ready", upd_ready, 0);
    w = n_writes;
    btb_wbusy = 0;
    chk("pop_cyc_ready", upd_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_pop", upd_ready, 1);
    drain();
    chk("burst_writes", n_writes - w, 4);

    btb_wbusy = 1;
    push(32'h1C00_0010, 32'h1C00_0800, 1, 0, 0);
    push(32'h1C00_0050, 32'h1C00_0804, 1, 0, 0);
    push(32'h1C00_0090, 32'h1C00_0808, 1, 0, 0);
    btb_wbusy = 0;
    reset = 1;
    model_clear();
    @(posedge clk); #1;
    reset = 0;
    chk("mid_rst_ready", upd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_no_we", btb_we, 0);
      @(posedge clk); #1;
    end
    push(32'h1C00_0010, 32'h1C00_0900, 1, 0, 0);
    @(posedge clk); #1;
    chk("post_rst_way0", btb_windex, 8);
    drain();

    w = n_writes;
    for (int i = 0; i < 10; i++) begin
      chk("b2b_ready", upd_ready, 1);
      push(32'h2000_0000 + 32'(i * 36), 32'h3000_0000 + 32'(i),
           1, 1'(i % 2), 5'(i + 3));
    end
    drain();
    chk("b2b_writes", n_writes - w, 10);
    chk("sb_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
